// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the sequential 3-to-8 one-hot decoder.
package onehot_dec_pkg;

    localparam int IN_W  = 3;
    localparam int OUT_W = 1 << IN_W;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_e;

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_3x8.sv
// Combinational code-to-line decoder; "none" forces an all-zero line.
module dec_3x8
    import onehot_dec_pkg::*;
(
    input  logic [IN_W-1:0]  code,
    input  logic             none,
    output logic [OUT_W-1:0] line
);

    always_comb begin
        line = none ? '0 : onehot(code);
    end

endmodule

// File: rtl/onehot_dec_3x8_seq.sv
// Accepts a code via valid/ready, holds the one-hot line for hold_len cycles,
// then inserts a one-cycle all-zero gap before the next code can be taken.
module onehot_dec_3x8_seq #(
    parameter int  IN_W   = 3,
    parameter int  HOLD_W = 8,
    localparam int OUT_W  = 2 ** IN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_code,
    input  logic              in_none,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              abort,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              done
);

    import onehot_dec_pkg::*;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic [OUT_W-1:0]    dec_line;

    dec_3x8 u_dec (
        .code (in_code),
        .none (in_none),
        .line (dec_line)
    );

    // Ready depends only on state, so a source may hold in_valid high safely.
    assign in_ready = (state_q == IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_d       = dec_line;
                    // Counter holds remaining cycles after the first; 0 behaves as 1.
                    cnt_d       = (hold_len == '0) ? '0 : hold_len - HOLD_W'(1);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = GAP;
                end else if (cnt_q == '0) begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = GAP;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                out_d       = '0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_onehot_dec_3x8_seq.sv
// Randomized and directed bench for onehot_dec_3x8_seq with a schedule-queue model.
module tb_onehot_dec_3x8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_none;
    logic [7:0] hold_len;
    logic       abort;
    logic [7:0] out;
    logic       out_valid;
    logic       done;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    onehot_dec_3x8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_none   (in_none),
        .hold_len  (hold_len),
        .abort     (abort),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Model: each entry is what the outputs must show during one cycle.
    typedef struct packed {
        logic [7:0] o;
        logic       v;
        logic       d;
        logic       r;
    } ent_t;

    localparam ent_t IDLE_E = '{o: 8'h00, v: 1'b0, d: 1'b0, r: 1'b1};
    localparam ent_t GAP_E  = '{o: 8'h00, v: 1'b0, d: 1'b0, r: 1'b0};
    localparam ent_t DONE_E = '{o: 8'h00, v: 1'b0, d: 1'b1, r: 1'b0};

    ent_t       cur = IDLE_E;
    ent_t       sched[$];
    int         m_n;
    logic [7:0] m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sched.delete();
            cur = IDLE_E;
        end else if (cur.r && in_valid) begin
            m_n   = (hold_len == 8'd0) ? 1 : int'(hold_len);
            m_val = in_none ? 8'd0 : 8'(1 << in_code);
            for (int i = 0; i < m_n; i++)
                sched.push_back('{o: m_val, v: 1'b1, d: 1'b0, r: 1'b0});
            sched.push_back(DONE_E);
            cur = sched.pop_front();
        end else if (cur.v && abort) begin
            sched.delete();
            cur = GAP_E;
        end else begin
            cur = (sched.size() > 0) ? sched.pop_front() : IDLE_E;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int penc(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++)
            if (v[i]) c = i;
        return c;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out", 32'(out), 32'(cur.o));
            chk("out_valid", 32'(out_valid), 32'(cur.v));
            chk("done", 32'(done), 32'(cur.d));
            chk("in_ready", 32'(in_ready), 32'(cur.r && !rst));
            chk("onehot_inv", 32'($countones(out) <= 1), 32'd1);
        end
    end

    task automatic send(input logic [2:0] c, input logic n, input logic [7:0] h);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = c;
        in_none  = n;
        hold_len = h;
        while (!in_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_code  = 3'($urandom);
        hold_len = 8'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    int cnt;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; in_none = 1'b0;
        hold_len = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Code 5, hold 3
        send(3'd5, 1'b0, 8'd3);
        chk("t1_c1_out", 32'(out), 32'h20);
        @(negedge clk);
        @(negedge clk);
        chk("t1_c3_out", 32'(out), 32'h20);
        chk("t1_c3_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t1_c4_out", 32'(out), 32'h00);
        chk("t1_c4_done", 32'(done), 32'd1);
        chk("t1_c4_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t1_c5_ready", 32'(in_ready), 32'd1);

        // Hold 0 acts as 1
        send(3'd0, 1'b0, 8'd0);
        chk("t2_c1_out", 32'(out), 32'h01);
        @(negedge clk);
        chk("t2_c2_out", 32'(out), 32'h00);
        chk("t2_c2_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t2_c3_ready", 32'(in_ready), 32'd1);

        // in_valid held high across two codes
        @(negedge clk);
        in_valid = 1'b1; in_code = 3'd7; in_none = 1'b0; hold_len = 8'd2;
        @(negedge clk);
        chk("t3_c1_out", 32'(out), 32'h80);
        in_code = 3'd2;
        @(negedge clk);
        chk("t3_c2_out", 32'(out), 32'h80);
        @(negedge clk);
        chk("t3_c3_out", 32'(out), 32'h00);
        @(negedge clk);
        @(negedge clk);
        chk("t3_c5_out", 32'(out), 32'h04);
        in_valid = 1'b0;
        wait_idle();

        // Abort on the third hold cycle
        send(3'd4, 1'b0, 8'd10);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_abort_out", 32'(out), 32'h00);
        chk("t4_abort_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("t4_idle_ready", 32'(in_ready), 32'd1);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_idle_abort_ready", 32'(in_ready), 32'd1);
        abort = 1'b0;

        // Asynchronous reset in the middle of a hold
        send(3'd6, 1'b0, 8'd5);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_out", 32'(out), 32'h00);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_post_ready", 32'(in_ready), 32'd1);
        send(3'd1, 1'b0, 8'd2);
        chk("t5_code1_out", 32'(out), 32'h02);
        wait_idle();

        // Loopback through a priority encoder
        for (int c = 0; c < 8; c++) begin
            send(3'(c), 1'b0, 8'($urandom_range(1, 4)));
            chk("loopback", 32'(penc(out)), 32'(c));
            wait_idle();
        end
        send(3'd3, 1'b1, 8'd3);
        chk("none_out", 32'(out), 32'h00);
        chk("none_valid", 32'(out_valid), 32'd1);
        wait_idle();

        // Longest hold
        send(3'd3, 1'b0, 8'd255);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (!out_valid) break;
            cnt++;
            @(negedge clk);
        end
        chk("hold255_len", 32'(cnt), 32'd255);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_code  = 3'($urandom);
            in_none  = ($urandom_range(0, 7) == 0);
            hold_len = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            abort    = ($urandom_range(0, 9) == 0);
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
